// File: rtl/pipelined_instruction_decode.sv
// RV32I decode stage: turns fetch words into decoded bundles held in a
// small in-order queue, with flush and illegal-instruction accounting.
module pipelined_instruction_decode #(
    parameter int         XLEN         = 32,
    parameter int         DEPTH        = 2,
    parameter logic [6:0] DEBUG_OPCODE = 7'b0001011,
    parameter int         COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instruction,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [10:0]            out_opcode_selection,
    output logic [4:0]             out_source_reg_1,
    output logic [4:0]             out_source_reg_2,
    output logic [4:0]             out_destination_reg,
    output logic [2:0]             out_subfunction_3,
    output logic [6:0]             out_subfunction_7,
    output logic [XLEN-1:0]        out_immediate,
    output logic                   out_illegal,
    output logic [COUNT_WIDTH-1:0] illegal_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [10:0]     sel;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    logic [31:0] instr;
    logic [10:0] sel;
    logic [31:0] imm32;
    bundle_t     dec;

    assign instr = in_instruction;

    // Class and immediate come from the opcode alone; anything
    // unmatched leaves sel and imm32 at zero and is flagged illegal.
    always_comb begin
        sel   = '0;
        imm32 = '0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                7'b0110111: begin
                    sel[0] = 1'b1;
                    imm32  = {instr[31:12], 12'b0};
                end
                7'b0010111: begin
                    sel[1] = 1'b1;
                    imm32  = {instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    sel[2] = 1'b1;
                    imm32  = {{12{instr[31]}}, instr[19:12],
                              instr[20], instr[30:21], 1'b0};
                end
                7'b1100111: begin
                    sel[3] = 1'b1;
                    imm32  = {{20{instr[31]}}, instr[31:20]};
                end
                7'b1100011: begin
                    sel[4] = 1'b1;
                    imm32  = {{20{instr[31]}}, instr[7],
                              instr[30:25], instr[11:8], 1'b0};
                end
                7'b0000011: begin
                    sel[5] = 1'b1;
                    imm32  = {{20{instr[31]}}, instr[31:20]};
                end
                7'b0100011: begin
                    sel[6] = 1'b1;
                    imm32  = {{20{instr[31]}}, instr[31:25],
                              instr[11:7]};
                end
                7'b0010011: begin
                    sel[7] = 1'b1;
                    imm32  = {{20{instr[31]}}, instr[31:20]};
                end
                7'b0110011: begin
                    sel[8] = 1'b1;
                end
                7'b0001111: begin
                    sel[9] = 1'b1;
                    imm32  = {{20{instr[31]}}, instr[31:20]};
                end
                DEBUG_OPCODE: begin
                    sel[10] = 1'b1;
                    imm32   = {{20{instr[31]}}, instr[31:20]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.sel     = sel;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.f3      = instr[14:12];
        dec.f7      = instr[31:25];
        dec.imm     = XLEN'($signed(imm32));
        dec.illegal = (sel == 11'd0);
    end

    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    bundle_t       mem [DEPTH];
    bundle_t       head;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Survives flush on purpose: it counts accepted illegal words.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_count <= '0;
        end else if (push && dec.illegal && !(&illegal_count)) begin
            illegal_count <= illegal_count + 1'b1;
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc               = head.pc;
    assign out_opcode_selection = head.sel;
    assign out_source_reg_1     = head.rs1;
    assign out_source_reg_2     = head.rs2;
    assign out_destination_reg  = head.rd;
    assign out_subfunction_3    = head.f3;
    assign out_subfunction_7    = head.f7;
    assign out_immediate        = head.imm;
    assign out_illegal          = head.illegal;

endmodule

// File: tb/tb_pipelined_instruction_decode.sv
// Bench for pipelined_instruction_decode: queue-level model plus
// hand-computed literal checks (XLEN=64, DEPTH=2, COUNT_WIDTH=2).
module tb_pipelined_instruction_decode;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int CWID  = 2;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [10:0]     out_opcode_selection;
    logic [4:0]      out_source_reg_1;
    logic [4:0]      out_source_reg_2;
    logic [4:0]      out_destination_reg;
    logic [2:0]      out_subfunction_3;
    logic [6:0]      out_subfunction_7;
    logic [XLEN-1:0] out_immediate;
    logic            out_illegal;
    logic [CWID-1:0] illegal_count;

    pipelined_instruction_decode #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .DEBUG_OPCODE(7'b0001011),
        .COUNT_WIDTH(CWID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instruction(in_instruction),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_opcode_selection(out_opcode_selection),
        .out_source_reg_1(out_source_reg_1),
        .out_source_reg_2(out_source_reg_2),
        .out_destination_reg(out_destination_reg),
        .out_subfunction_3(out_subfunction_3),
        .out_subfunction_7(out_subfunction_7),
        .out_immediate(out_immediate),
        .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [10:0] sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    int   n_tests;
    int   n_fail;
    bit   chk_en;
    exp_t q[$];
    int   mcnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t decode(input logic [31:0] w,
                                    input logic [63:0] pc);
        exp_t   e;
        int     cls;
        longint v;
        e     = '0;
        e.pc  = pc;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        case (w[6:0])
            7'h37: cls = 0;
            7'h17: cls = 1;
            7'h6F: cls = 2;
            7'h67: cls = 3;
            7'h63: cls = 4;
            7'h03: cls = 5;
            7'h23: cls = 6;
            7'h13: cls = 7;
            7'h33: cls = 8;
            7'h0F: cls = 9;
            7'h0B: cls = 10;
            default: cls = -1;
        endcase
        if (w[1:0] != 2'b11) cls = -1;
        v = 0;
        case (cls)
            0, 1: v = $signed({w[31:12], 12'h000});
            2: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            4: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            6: v = $signed({w[31:25], w[11:7]});
            3, 5, 7, 9, 10: v = $signed(w[31:20]);
            default: v = 0;
        endcase
        if (cls < 0) begin
            e.ill = 1'b1;
        end else begin
            e.sel = 11'(1 << cls);
            e.imm = v;
        end
        return e;
    endfunction

    task automatic check(input string name,
                         input logic [191:0] act,
                         input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference queue: advances on each rising edge from the bench inputs.
    always @(posedge clk) begin
        bit   pu;
        bit   po;
        exp_t e;
        if (reset) begin
            q.delete();
            mcnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            pu = in_valid && (q.size() < DEPTH);
            po = out_ready && (q.size() > 0);
            e  = decode(in_instruction, in_pc);
            if (po) void'(q.pop_front());
            if (pu) begin
                q.push_back(e);
                if (e.ill && mcnt < (1 << CWID) - 1) mcnt++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t want;
        exp_t got;
        if (chk_en) begin
            want = (q.size() > 0) ? q[0] : '0;
            got  = {out_pc, out_opcode_selection, out_source_reg_1,
                    out_source_reg_2, out_destination_reg,
                    out_subfunction_3, out_subfunction_7,
                    out_immediate, out_illegal};
            check("model_out_valid", out_valid, q.size() > 0);
            check("model_in_ready", in_ready, q.size() < DEPTH);
            check("model_illegal_count", illegal_count, mcnt);
            check("model_bundle", got, want);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] prog [20] = '{
        32'h12345037, 32'h008000EF, 32'h00001097, 32'h000080E7,
        32'hFE000EE3, 32'h0040A103, 32'h0020A223, 32'h002081B3,
        32'h0000000F, 32'h0030010B, 32'hFFF00093, 32'hFE20AE23,
        32'h80000537, 32'h00000000, 32'hFFDFF06F, 32'h40208233,
        32'h00452283, 32'h7FF00113, 32'h00F00063, 32'h0000100F
    };

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 0;
        mcnt    = 0;
        reset = 1; flush = 0; in_valid = 0;
        in_instruction = 0; in_pc = 0; out_ready = 0;
        tick();
        tick();
        chk_en = 1;
        reset  = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_illegal_count", illegal_count, 0);
        check("rst_out_illegal", out_illegal, 0);

        // addi x1,x0,5
        in_valid = 1; in_instruction = 32'h00500093; in_pc = 64'h100;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("addi_valid", out_valid, 1);
        check("addi_sel", out_opcode_selection, 11'h080);
        check("addi_rd", out_destination_reg, 1);
        check("addi_rs1", out_source_reg_1, 0);
        check("addi_imm", out_immediate, 5);
        check("addi_pc", out_pc, 64'h100);
        check("addi_illegal", out_illegal, 0);
        out_ready = 1;
        tick();
        out_ready = 0;

        // beq x0,x0,-4
        in_valid = 1; in_instruction = 32'hFE000EE3; in_pc = 64'h200;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("beq_imm", out_immediate, 64'hFFFFFFFFFFFFFFFC);
        check("beq_sel", out_opcode_selection, 11'h010);
        out_ready = 1;
        tick();
        out_ready = 0;

        // fill, stall a third word, then drain
        in_valid = 1; in_instruction = 32'h00100113; in_pc = 64'h300;
        tick();
        in_instruction = 32'h00200193; in_pc = 64'h304;
        tick();
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_head_pc", out_pc, 64'h300);
        in_instruction = 32'h00300213; in_pc = 64'h308;
        tick();
        tick();
        @(negedge clk);
        check("stall_head_pc", out_pc, 64'h300);
        out_ready = 1;
        tick();
        @(negedge clk);
        check("pop1_in_ready", in_ready, 1);
        check("pop1_head_pc", out_pc, 64'h304);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("pop2_head_pc", out_pc, 64'h308);
        tick();
        out_ready = 0;
        @(negedge clk);
        check("drained_valid", out_valid, 0);

        // illegal words
        in_valid = 1; in_instruction = 32'h00000000; in_pc = 64'h400;
        tick();
        in_instruction = 32'hFFFFFFFF; in_pc = 64'h404;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("ill_count2", illegal_count, 2);
        check("ill_flag", out_illegal, 1);
        check("ill_sel", out_opcode_selection, 0);
        check("ill_imm", out_immediate, 0);

        // flush while full with a concurrent push
        in_valid = 1; in_instruction = 32'h00500093; in_pc = 64'h500;
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_count_kept", illegal_count, 2);
        tick();
        @(negedge clk);
        check("flush_not_delivered", out_valid, 0);

        // saturation: three more illegal pushes
        out_ready = 1;
        in_valid = 1; in_instruction = 32'h00000000; in_pc = 64'h600;
        tick();
        tick();
        tick();
        in_valid = 0;
        tick();
        @(negedge clk);
        check("ill_saturate", illegal_count, 3);
        out_ready = 0;

        // reset mid-stream
        in_valid = 1; in_instruction = 32'h00100113; in_pc = 64'h700;
        tick();
        in_pc = 64'h704;
        tick();
        reset = 1; in_pc = 64'h708;
        tick();
        reset = 0; in_valid = 0;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_count", illegal_count, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        @(negedge clk);
        check("midrst_no_leak", out_valid, 0);

        // back-to-back stream
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1;
            in_instruction = prog[i];
            in_pc = 64'h1000 + 64'(4 * i);
            tick();
            @(negedge clk);
            check("stream_pc", out_pc, 64'h1000 + 64'(4 * i));
            if (i == 0) begin
                check("lui_imm", out_immediate, 64'h12345000);
                check("lui_sel", out_opcode_selection, 11'h001);
            end
            if (i == 1) begin
                check("jal_imm", out_immediate, 64'h8);
                check("jal_sel", out_opcode_selection, 11'h004);
            end
        end
        in_valid = 0;
        tick();
        tick();
        tick();
        @(negedge clk);
        check("stream_drained", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
